// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, instruction
// modes, condition codes and the program-counter advance rule.
package instr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_IMM  = 2'b00,
        MODE_ALU  = 2'b01,
        MODE_COPY = 2'b10,
        MODE_COND = 2'b11
    } mode_t;

    localparam logic [2:0] CC_NEVER  = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_LT     = 3'b010;
    localparam logic [2:0] CC_LE     = 3'b011;
    localparam logic [2:0] CC_ALWAYS = 3'b100;
    localparam logic [2:0] CC_NE     = 3'b101;
    localparam logic [2:0] CC_GE     = 3'b110;
    localparam logic [2:0] CC_GT     = 3'b111;

    localparam logic [7:0] PC_RESET = 8'h00;

    // A taken branch loads the target; anything else steps by one and wraps.
    function automatic logic [7:0] next_pc(input logic [7:0] cur,
                                           input logic       taken,
                                           input logic [7:0] target);
        logic [7:0] result;
        if (taken) begin
            result = target;
        end else begin
            result = cur + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-memory fetch bus: request/address from the sequencer,
// acknowledge/data back from memory in the same cycle.
interface instr_sequencer_if;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/instr_sequencer_cond_eval.sv
// Combinational branch-condition evaluator: tests a signed 8-bit value
// against one of eight condition codes.
module cond_eval
    import instr_seq_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [7:0] value,
    output logic       taken
);

    logic zero_s;
    logic neg_s;

    assign zero_s = (value == 8'h00);
    assign neg_s  = value[7];

    // Map the condition code onto the zero/negative flags of the value.
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_NEVER:  taken = 1'b0;
            CC_EQ:     taken = zero_s;
            CC_LT:     taken = neg_s;
            CC_LE:     taken = neg_s | zero_s;
            CC_ALWAYS: taken = 1'b1;
            CC_NE:     taken = ~zero_s;
            CC_GE:     taken = ~neg_s;
            CC_GT:     taken = ~neg_s & ~zero_s;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Four-state instruction sequencer: fetches a byte from program memory,
// decodes mode/field, evaluates a branch condition and advances pc.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int    UUID = 0,
    parameter string NAME = ""
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    instr_sequencer_if.master         mem,
    input  logic [7:0]                cond_val,
    input  logic [7:0]                jump_target,
    output logic                      exec_valid,
    output logic [1:0]                mode,
    output logic [5:0]                field,
    output logic [7:0]                pc,
    output logic                      busy
);

    state_t     state_r;
    logic [7:0] pc_r;
    logic [7:0] ir_r;
    logic       mem_req_r;
    logic       exec_valid_r;
    logic [1:0] mode_r;
    logic [5:0] field_r;
    logic       busy_r;
    logic       taken_r;
    logic [7:0] target_r;
    logic       taken_s;

    cond_eval u_cond_eval (
        .cond  (ir_r[2:0]),
        .value (cond_val),
        .taken (taken_s)
    );

    // Sequencer FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            pc_r         <= PC_RESET;
            ir_r         <= 8'h00;
            mem_req_r    <= 1'b0;
            exec_valid_r <= 1'b0;
            mode_r       <= 2'b00;
            field_r      <= 6'b000000;
            busy_r       <= 1'b0;
            taken_r      <= 1'b0;
            target_r     <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        state_r   <= ST_FETCH;
                        mem_req_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (mem.mem_ack) begin
                        ir_r      <= mem.mem_data;
                        mem_req_r <= 1'b0;
                        state_r   <= ST_DECODE;
                    end else begin
                        mem_req_r <= 1'b1;
                        state_r   <= ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    // Branch inputs are frozen here so EXEC ignores later changes.
                    mode_r       <= ir_r[7:6];
                    field_r      <= ir_r[5:0];
                    taken_r      <= (ir_r[7:6] == MODE_COND) && taken_s;
                    target_r     <= jump_target;
                    exec_valid_r <= 1'b1;
                    state_r      <= ST_EXEC;
                end
                ST_EXEC: begin
                    exec_valid_r <= 1'b0;
                    pc_r         <= next_pc(pc_r, taken_r, target_r);
                    if (run) begin
                        state_r   <= ST_FETCH;
                        mem_req_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    mem_req_r    <= 1'b0;
                    exec_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req  = mem_req_r;
    assign mem.mem_addr = pc_r;
    assign exec_valid   = exec_valid_r;
    assign mode         = mode_r;
    assign field        = field_r;
    assign pc           = pc_r;
    assign busy         = busy_r;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter UUID, default 0, instance identifier; no functional effect.
REQ-002 Parameter NAME, default "", instance label; no functional effect.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 run  input  1  1 = fetch and execute continuously; 0 = stop at the next instruction boundary.
REQ-006 mem_req  output  1  program-memory fetch request.
REQ-007 mem_addr  output  8  fetch address, equal to pc.
REQ-008 mem_ack  input  1  fetch complete; mem_data valid in the same cycle.
REQ-009 mem_data  input  8  instruction byte.
REQ-010 cond_val  input  8  signed value tested by condition instructions.
REQ-011 jump_target  input  8  branch destination for taken conditions.
REQ-012 exec_valid  output  1  one-cycle strobe: the decoded instruction executes this cycle.
REQ-013 mode  output  2  instruction bits 7:6 (00 IMM, 01 ALU, 10 COPY, 11 COND).
REQ-014 field  output  6  instruction bits 5:0.
REQ-015 pc  output  8  program counter.
REQ-016 busy  output  1  high in any state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC.
REQ-018 IDLE SHALL move to FETCH when run=1; otherwise it SHALL stay in IDLE.
REQ-019 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal pc; mem_req SHALL stay high until mem_ack=1.
REQ-020 On the cycle with mem_ack=1 in FETCH, the FSM SHALL capture mem_data into the instruction register and go to DECODE; mem_ack outside FETCH SHALL be ignored.
REQ-021 DECODE SHALL drive mode and field from the instruction register, evaluate the condition, and go to EXEC.
REQ-022 EXEC SHALL assert exec_valid for exactly one cycle and update pc.
REQ-023 After EXEC, the FSM SHALL go to FETCH if run=1, else to IDLE.
REQ-024 A zero-wait fetch SHALL take 3 cycles per instruction (FETCH, DECODE, EXEC).
REQ-025 Condition codes use field[2:0]: 000 never, 001 ==0, 010 <0, 011 <=0, 100 always, 101 !=0, 110 >=0, 111 >0; cond_val is two's complement.
REQ-026 In EXEC, a COND instruction with a true condition SHALL load pc <= jump_target.
REQ-027 In EXEC, every other instruction (including a false COND) SHALL set pc <= pc+1, modulo 256 (0xFF wraps to 0x00).
REQ-028 jump_target and cond_val SHALL be sampled in DECODE; changes during EXEC have no effect.
REQ-029 mode and field SHALL hold their last decoded value outside DECODE/EXEC.
REQ-030 Deasserting run during FETCH or DECODE SHALL NOT abort the current instruction.

Reset
REQ-031 While rst=0, the block SHALL force the following, regardless of clk: state=IDLE, pc=0x00, instruction register=0x00, mem_req=0, exec_valid=0, mode=0, field=0, busy=0.
REQ-032 Reset asserted during a pending fetch SHALL drop mem_req immediately; no instruction SHALL execute afterwards until a new fetch.
REQ-033 The first fetch after reset release SHALL use address 0x00.

Structure
REQ-034 State encoding, mode constants (IMM/ALU/COPY/COND) and the condition-code constants SHALL live in a shared package, instr_seq_pkg.
REQ-035 Condition evaluation SHALL be a combinational sub-module, cond_eval (inputs cond 3b and value 8b; output taken 1b).

Verification
REQ-036 Reset release with run=1 and mem_ack tied to 1, program 0x05,0x41,0x9A -> mode/field 00/05, 01/01, 10/1A on exec_valid pulses 3 cycles apart; pc steps 0, 1, 2, 3.
REQ-037 mem_ack delayed 4 cycles -> mem_req and mem_addr held steady for 4 cycles; exactly one exec_valid per instruction.
REQ-038 COND 0xC1 with cond_val=0x00 and jump_target=0x40 -> pc=0x40; the same instruction with cond_val=0x80 -> pc increments by 1.
REQ-039 pc=0xFF with a non-branch instruction -> next pc=0x00, and the next mem_addr is 0x00.
REQ-040 rst pulled low mid-FETCH -> mem_req falls in the same cycle and pc=0; after release, the fetch restarts at 0x00.
REQ-041 run dropped during DECODE -> the current EXEC completes, then the FSM enters IDLE with busy=0 and no further mem_req.
